// File: rtl/toggle_period_meter.sv
// toggle_period_meter
//   Receive-side monitor for a slow square wave (e.g. an LED blink output).
//   Measures the period (rise to rise) and the high time (rise to fall) of the
//   asynchronous input sig_in in Clk50M cycles. It flags loss of activity when
//   no rising edge arrives within TIMEOUT cycles.
//
//   Optional feature macro: PERIOD_CHECK_EN
//     defined   -> period_ok flags a period within EXP_PERIOD +/- TOL
//     undefined -> period_ok is tied to 0
//
// Ports
//   Clk50M     in   1      system clock
//   Rst_n      in   1      asynchronous reset, active low
//   sig_in     in   1      asynchronous square wave under measurement
//   period     out  CNT_W  last complete period, rise to rise, in cycles
//   high_time  out  CNT_W  high portion of that period, in cycles
//   valid      out  1      one-cycle pulse when period/high_time update
//   timeout    out  1      sticky activity-loss flag, cleared by next valid
//   period_ok  out  1      period within tolerance (PERIOD_CHECK_EN only)
//
// TIMEOUT must be below 2**CNT_W so that cnt never wraps.

module toggle_period_meter #(
    parameter int unsigned CNT_W      = 27,
    parameter int unsigned TIMEOUT    = 100_000_000,
    parameter int unsigned EXP_PERIOD = 50_000_000,
    parameter int unsigned TOL        = 1_000
) (
    input  logic             Clk50M,
    input  logic             Rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             period_ok
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             sync1, sync2, sig_d;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] hi_cnt, hi_cnt_nxt;
    logic [CNT_W-1:0] period_nxt, high_time_nxt;
    logic             valid_nxt, timeout_nxt;
    logic             at_limit;
    logic             to_evt;

    // Two-flop synchroniser plus one edge-detect flop. Every edge sees the
    // same latency, so rise-to-rise and rise-to-fall distances are exact.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            sig_d <= sync2;
        end
    end

    assign rise     = sync2 & ~sig_d;
    assign fall     = ~sync2 & sig_d;
    assign cnt_inc  = cnt + 1'b1;
    assign at_limit = (cnt == CNT_LIMIT);

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi_cnt    <= hi_cnt_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hi_cnt_nxt    = hi_cnt;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;
        to_evt        = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (rise) begin
                    state_nxt = HIGH;
                end
            end

            HIGH: begin
                // A rise cannot occur here; the limit check wins over a fall
                // arriving in the very cycle the limit is reached.
                cnt_nxt = cnt_inc;
                if (at_limit) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    to_evt      = 1'b1;
                end else if (fall) begin
                    hi_cnt_nxt = cnt_inc;
                    state_nxt  = LOW;
                end
            end

            LOW: begin
                cnt_nxt = cnt_inc;
                if (rise) begin
                    period_nxt    = cnt_inc;
                    high_time_nxt = hi_cnt;
                    valid_nxt     = 1'b1;
                    timeout_nxt   = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = HIGH;
                end else if (at_limit) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                    to_evt      = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef PERIOD_CHECK_EN
    localparam int unsigned PER_MIN = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam int unsigned PER_MAX = EXP_PERIOD + TOL;

    // Evaluated on the value being latched into period, so period_ok
    // updates in the same cycle as period and valid.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            period_ok <= 1'b0;
        end else if (valid_nxt) begin
            period_ok <= (32'(cnt_inc) >= PER_MIN) && (32'(cnt_inc) <= PER_MAX);
        end else if (to_evt) begin
            period_ok <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXP_PERIOD, TOL, to_evt};
    assign period_ok  = 1'b0;
`endif

endmodule
